// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one op in flight, valid/ready on both sides, tag passthrough and synchronous flush.
module rv32m_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int EARLY_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e            state_reg, state_next;
    logic [2:0]        op_reg, op_next;
    logic [TAG_W-1:0]  tag_reg, tag_next, out_tag_reg, out_tag_next;
    logic              neg_reg, neg_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [2*XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0]   opb_reg, opb_next, out_result_reg, out_result_next;

    // Operand decode for the accept cycle
    logic            a_signed, b_signed, sign_a, sign_b, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        a_signed = (in_funct3 == 3'd1) || (in_funct3 == 3'd2) ||
                   (in_funct3 == 3'd4) || (in_funct3 == 3'd6);
        b_signed = (in_funct3 == 3'd1) || (in_funct3 == 3'd4) || (in_funct3 == 3'd6);
        sign_a   = a_signed & in_a[XLEN-1];
        sign_b   = b_signed & in_b[XLEN-1];
        mag_a    = sign_a ? -in_a : in_a;
        mag_b    = sign_b ? -in_b : in_b;
        div_zero = (in_b == '0);
        div_ovf  = ((in_funct3 == 3'd4) || (in_funct3 == 3'd6)) &&
                   (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    end

    // acc_reg holds {high, low} of the product, or {remainder, quotient} while dividing
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_step, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
        div_shift = acc_reg[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opb_reg};
        if (op_reg[2]) begin
            if (div_diff[XLEN])
                acc_step = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
            else
                acc_step = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_reg[XLEN-1:1]};
        end
        prod_fix = neg_reg ? -acc_reg : acc_reg;
        quo_fix  = neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
        rem_fix  = neg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
        case (op_reg)
            3'd0:                fix_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_result = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fix_result = quo_fix;
            default:             fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        tag_next        = tag_reg;
        neg_next        = neg_reg;
        count_next      = count_reg;
        acc_next        = acc_reg;
        opb_next        = opb_reg;
        out_result_next = out_result_reg;
        out_tag_next    = out_tag_reg;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (in_valid) begin
                    op_next    = in_funct3;
                    tag_next   = in_tag;
                    opb_next   = mag_b;
                    acc_next   = {{XLEN{1'b0}}, mag_a};
                    count_next = CNT_W'(XLEN);
                    state_next = S_CALC;
                    case (in_funct3)
                        3'd1, 3'd2: neg_next = sign_a ^ sign_b;
                        // Divide-by-zero quotient stays all ones whatever the signs
                        3'd4:       neg_next = (sign_a ^ sign_b) & ~div_zero;
                        3'd6:       neg_next = sign_a;
                        default:    neg_next = 1'b0;
                    endcase
                    // Early out preloads the state the full iteration would end in
                    if ((EARLY_OUT != 0) && in_funct3[2] && (div_zero || div_ovf)) begin
                        count_next = '0;
                        if (div_zero)
                            acc_next = {mag_a, {XLEN{1'b1}}};
                    end
                end
                S_CALC: begin
                    if (count_reg != '0) begin
                        acc_next   = acc_step;
                        count_next = count_reg - CNT_W'(1);
                    end else begin
                        out_result_next = fix_result;
                        out_tag_next    = tag_reg;
                        state_next      = S_DONE;
                    end
                end
                S_DONE: if (out_ready) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            op_reg         <= '0;
            tag_reg        <= '0;
            neg_reg        <= 1'b0;
            count_reg      <= '0;
            acc_reg        <= '0;
            opb_reg        <= '0;
            out_result_reg <= '0;
            out_tag_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            tag_reg        <= tag_next;
            neg_reg        <= neg_next;
            count_reg      <= count_next;
            acc_reg        <= acc_next;
            opb_reg        <= opb_next;
            out_result_reg <= out_result_next;
            out_tag_reg    <= out_tag_next;
        end
    end

    assign in_ready   = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign out_valid  = (state_reg == S_DONE);
    assign out_result = out_result_reg;
    assign out_tag    = out_tag_reg;
endmodule
